alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (DATA_WIDTH operands, 4-bit ctl) between NUM_REQ requesters, e.g. execute stage and branch/address unit.
- Round-robin arbitration with valid/ready request and response handshakes.
- Registered operands to the ALU and a registered result back to the owning requester.
- Sits between requesters and the ALU instance; the ALU itself stays outside this block.

Parameters:
- DATA_WIDTH, 32, operand/result width
- NUM_REQ, 2, number of requesters (2..8)
- CTL_WIDTH, 4, ALU control width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept
- req_a  in  NUM_REQ*DATA_WIDTH  packed operand A, requester i at slice i
- req_b  in  NUM_REQ*DATA_WIDTH  packed operand B
- req_ctl  in  NUM_REQ*CTL_WIDTH  packed ALU op code
- rsp_valid  out  NUM_REQ  result valid, one-hot to owner
- rsp_ready  in  NUM_REQ  per-requester result accept
- rsp_result  out  DATA_WIDTH  shared result bus, qualified by rsp_valid
- rsp_err  out  1  illegal-op flag, qualified by rsp_valid
- alu_a, alu_b  out  DATA_WIDTH  operands to shared ALU
- alu_ctl  out  CTL_WIDTH  op to shared ALU
- alu_result  in  DATA_WIDTH  ALU combinational result

Behaviour:
- Clock and reset: single clk domain; rst_n asynchronous active-low.
- FSM states: IDLE, EXEC, RESP.
- Reset values: state=IDLE; rr_ptr=0; alu_a/alu_b/alu_ctl=0; rsp_result=0; rsp_err=0; owner=0; req_ready=0; rsp_valid=0.
- IDLE, grant:
  - grant = first i with req_valid[i] searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[grant]=1, combinational, same cycle; all other req_ready=0.
  - On handshake: latch that slice's a/b/ctl into the alu_* registers, owner<=grant, rr_ptr<=grant+1 (mod NUM_REQ), go to EXEC.
  - With no req_valid: stay in IDLE.
- EXEC:
  - alu_* hold the latched operands for one full cycle.
  - At cycle end: rsp_result<=alu_result, go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_result and rsp_err stable until rsp_ready[owner].
  - On rsp_ready[owner]: if any req_valid, perform the IDLE grant in this same cycle (back-to-back) and go to EXEC; otherwise go to IDLE.
  - rsp_ready of non-owners is ignored.
- Latency: request accept to rsp_valid = 2 cycles; sustained throughput 1 op / 2 cycles with rsp_ready held high.
- req_ready is only high in IDLE, or in RESP with owner rsp_ready=1; never while EXEC.
- Requester with req_valid high and no grant keeps its request; the arbiter never drops it.
- Fairness: a continuously-valid requester is granted within NUM_REQ grants.
- alu_* hold their last value in IDLE/RESP; no operand zeroing.
- rst_n low mid-EXEC/RESP: in-flight op discarded, no rsp_valid after release, state to IDLE, rr_ptr=0.

Optional Feature:
- Macro: ALU_ARB_CTL_CHECK_EN.
- Defined:
  - req_ctl > ALU_OP_MAX (8) is illegal.
  - On accept of an illegal op, alu_ctl is loaded with 0 and the op still takes EXEC.
  - rsp_result=0, rsp_err=1 in RESP.
- Undefined:
  - ctl passed unchecked to the ALU; rsp_result=alu_result; rsp_err tied 0.

Decomposition:
- Package alu_pkg:
  - alu_op_e enumerating ALU op codes 0–8
  - ALU_OP_MAX=8
  - ALU_CTL_WIDTH=4
  - arbiter state enum arb_state_e {IDLE, EXEC, RESP}
- Sub-module rr_arbiter: NUM_REQ-wide round-robin priority pick from req_valid and rr_ptr, producing grant index and any_valid. Combinational only; pointer register stays in alu_arbiter.

Test Plan:
- Bench setup: NUM_REQ=2; bench stub drives alu_result = alu_a ^ alu_b.
- Single request: req0 a=0xFFFFFFFF, b=0xAAAAAAAA, ctl=2 -> req_ready[0] same cycle; rsp_valid[0]=1 two cycles later; rsp_result=0x55555555; rsp_err=0.
- Contention: req0 and req1 valid together from reset, held high, rsp_ready=1 -> grants 0,1,0,1; new rsp_valid every 2 cycles.
- Backpressure: rsp_ready[1]=0 for 5 cycles after rsp_valid[1] -> rsp_valid[1] and rsp_result held stable; req_ready=0 for all requesters throughout; accept resumes the cycle rsp_ready[1] rises.
- Async reset: rst_n pulsed low during EXEC of req1 (a=5, b=10) -> all outputs 0 immediately; no rsp_valid after release; next grant goes to req0.
- Illegal op with ALU_ARB_CTL_CHECK_EN defined: req0 ctl=0xF, a=0xF, b=4 -> alu_ctl=0 during EXEC; rsp_result=0; rsp_err=1.
- Illegal op without ALU_ARB_CTL_CHECK_EN: same stimulus -> rsp_result=0xB; rsp_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: ALU op codes, control width and arbiter FSM states.
package alu_pkg;

  localparam int ALU_OP_MAX    = 8;
  localparam int ALU_CTL_WIDTH = 4;

  typedef enum logic [ALU_CTL_WIDTH-1:0] {
    ALU_OP_AND = 4'd0,
    ALU_OP_OR  = 4'd1,
    ALU_OP_ADD = 4'd2,
    ALU_OP_SUB = 4'd3,
    ALU_OP_XOR = 4'd4,
    ALU_OP_SLL = 4'd5,
    ALU_OP_SRL = 4'd6,
    ALU_OP_SRA = 4'd7,
    ALU_OP_SLT = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   grant,
  output logic               any_valid
);

  int idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between NUM_REQ requesters.
// Optional ALU_ARB_CTL_CHECK_EN: ops above ALU_OP_MAX run as op 0 and return result 0 with rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int CTL_WIDTH  = ALU_CTL_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*CTL_WIDTH-1:0]    req_ctl,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_result,
  output logic                            rsp_err,
  output logic [DATA_WIDTH-1:0]           alu_a,
  output logic [DATA_WIDTH-1:0]           alu_b,
  output logic [CTL_WIDTH-1:0]            alu_ctl,
  input  logic [DATA_WIDTH-1:0]           alu_result
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
  logic [CTL_WIDTH-1:0]  alu_ctl_q, alu_ctl_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;

  logic [PTR_W-1:0]      grant;
  logic                  any_valid;
  logic                  accept;
  int                    grant_idx;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [CTL_WIDTH-1:0]  sel_ctl;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .any_valid (any_valid)
  );

  assign grant_idx = int'(grant);
  assign sel_a     = req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b     = req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_ctl   = req_ctl[grant_idx*CTL_WIDTH +: CTL_WIDTH];

`ifdef ALU_ARB_CTL_CHECK_EN
  logic illegal_q, illegal_d;
  logic rsp_err_q, rsp_err_d;
  logic sel_illegal;

  assign sel_illegal = int'(sel_ctl) > ALU_OP_MAX;
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctl_d    = alu_ctl_q;
    rsp_result_d = rsp_result_q;
    accept       = 1'b0;
`ifdef ALU_ARB_CTL_CHECK_EN
    illegal_d    = illegal_q;
    rsp_err_d    = rsp_err_q;
`endif

    case (state_q)
      IDLE: accept = any_valid;
      EXEC: begin
        rsp_result_d = alu_result;
`ifdef ALU_ARB_CTL_CHECK_EN
        if (illegal_q) rsp_result_d = '0;
        rsp_err_d = illegal_q;
`endif
        state_d = RESP;
      end
      RESP: begin
        // Back-to-back grant in the same cycle the owner drains its result.
        if (rsp_ready[owner_q]) begin
          if (any_valid) accept = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = EXEC;
      owner_d   = grant;
      rr_ptr_d  = (grant == PTR_W'(NUM_REQ-1)) ? '0 : grant + PTR_W'(1);
      alu_a_d   = sel_a;
      alu_b_d   = sel_b;
      alu_ctl_d = sel_ctl;
`ifdef ALU_ARB_CTL_CHECK_EN
      illegal_d = sel_illegal;
      if (sel_illegal) alu_ctl_d = '0;
`endif
    end
  end

  // req_ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept && rst_n)  req_ready[grant]   = 1'b1;
    if (state_q == RESP)  rsp_valid[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctl_q    <= alu_ctl_d;
      rsp_result_q <= rsp_result_d;
    end
  end

`ifdef ALU_ARB_CTL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`endif

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctl    = alu_ctl_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an XOR ALU stub and a response scoreboard.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int CW = 4;
`ifdef ALU_ARB_CTL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR*CW-1:0] req_ctl;
  logic [DW-1:0]    rsp_result, alu_a, alu_b, alu_result;
  logic             rsp_err;
  logic [CW-1:0]    alu_ctl;

  typedef struct {
    int          owner;
    logic [DW-1:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CTL_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctl    (req_ctl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctl    (alu_ctl),
    .alu_result (alu_result)
  );

  assign alu_result = alu_a ^ alu_b;
  always #5 clk = ~clk;

  function automatic exp_t model(int owner, logic [DW-1:0] a, logic [DW-1:0] b, logic [CW-1:0] ctl);
    exp_t e;
    e.owner = owner;
    e.res   = a ^ b;
    e.err   = 1'b0;
    if (CHECK_EN && int'(ctl) > 8) begin
      e.res = '0;
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic set_req(int i, logic [DW-1:0] a, logic [DW-1:0] b, logic [CW-1:0] c);
    req_a[i*DW +: DW]   = a;
    req_b[i*DW +: DW]   = b;
    req_ctl[i*CW +: CW] = c;
  endtask

  // Let combinational outputs settle, then record every accepted request.
  task automatic settle_and_log();
    #1;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i])
        sb.push_back(model(i, req_a[i*DW +: DW], req_b[i*DW +: DW], req_ctl[i*CW +: CW]));
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_ctl} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req_ready=%b rsp_valid=%b res=%h err=%b a=%h b=%h ctl=%h expected all 0",
               req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_ctl);
    end
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b expected 00", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    settle_and_log();
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset got rsp_valid=%b req_ready=%b expected 00 00", rsp_valid, req_ready);
    end
  endtask

  task automatic test_contention();
    int grants = 0;
    int resps  = 0;
    int cyc    = 0;
    int exp_g;
    exp_t e;
    logic [NR-1:0] ev;
    set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 4'd1);
    set_req(1, 32'hDEAD_BEEF, 32'h00FF_00FF, 4'd3);
    rsp_ready = 2'b11;
    while (cyc < 20 && (grants < 4 || resps < 4)) begin
      @(negedge clk);
      req_valid = (grants < 4) ? 2'b11 : 2'b00;
      settle_and_log();
      if (req_ready != '0) begin
        exp_g = grants % 2;
        checks++;
        if (req_ready !== NR'(1 << exp_g) || cyc != 2 * grants) begin
          errors++;
          $display("FAIL contention_grant got ready=%b at cycle %0d expected ready=%b at cycle %0d",
                   req_ready, cyc, NR'(1 << exp_g), 2 * grants);
        end
        grants++;
      end
      if (rsp_valid != '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL contention_rsp got unexpected rsp_valid=%b expected none", rsp_valid);
        end else begin
          e = sb.pop_front();
          ev = '0;
          ev[e.owner] = 1'b1;
          if (rsp_valid !== ev || rsp_result !== e.res || rsp_err !== e.err || cyc != 2 * resps + 2) begin
            errors++;
            $display("FAIL contention_rsp got v=%b res=%h err=%b cyc=%0d expected v=%b res=%h err=%b cyc=%0d",
                     rsp_valid, rsp_result, rsp_err, cyc, ev, e.res, e.err, 2 * resps + 2);
          end
        end
        resps++;
      end
      cyc++;
    end
    checks++;
    if (grants != 4 || resps != 4) begin
      errors++;
      $display("FAIL contention_timeout got grants=%0d resps=%0d expected 4 4", grants, resps);
    end
  endtask

  task automatic test_single();
    exp_t e;
    @(negedge clk);
    set_req(0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 4'd2);
    req_valid = 2'b01;
    settle_and_log();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b expected 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    settle_and_log();
    checks++;
    if (rsp_valid !== 2'b00 || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'hAAAA_AAAA || alu_ctl !== 4'd2) begin
      errors++;
      $display("FAIL single_exec got v=%b a=%h b=%h ctl=%h expected v=00 a=ffffffff b=aaaaaaaa ctl=2",
               rsp_valid, alu_a, alu_b, alu_ctl);
    end
    @(negedge clk);
    settle_and_log();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== 32'h5555_5555 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got v=%b res=%h err=%b expected v=01 res=55555555 err=0",
               rsp_valid, rsp_result, rsp_err);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL single_sb got empty scoreboard expected one entry");
    end else begin
      e = sb.pop_front();
      if (e.owner != 0 || rsp_result !== e.res) begin
        errors++;
        $display("FAIL single_sb got owner=%0d res=%h expected owner=0 res=%h", e.owner, rsp_result, e.res);
      end
    end
    @(negedge clk);
    settle_and_log();
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL single_done got v=%b ready=%b expected 00 00", rsp_valid, req_ready);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    @(negedge clk);
    set_req(1, 32'h1357_2468, 32'h0000_FFFF, 4'd4);
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    settle_and_log();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_grant got %b expected 10", req_ready);
    end
    @(negedge clk);
    set_req(0, 32'hCAFE_F00D, 32'h1111_1111, 4'd5);
    req_valid = 2'b01;
    settle_and_log();
    checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL bp_exec got ready=%b v=%b expected 00 00", req_ready, rsp_valid);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      settle_and_log();
      checks++;
      if (rsp_valid !== 2'b10 || rsp_result !== (32'h1357_2468 ^ 32'h0000_FFFF) || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b res=%h ready=%b expected v=10 res=%h ready=00",
                 k, rsp_valid, rsp_result, req_ready, 32'h1357_2468 ^ 32'h0000_FFFF);
      end
    end
    @(negedge clk);
    rsp_ready = 2'b11;
    settle_and_log();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_resume got ready=%b expected 01", req_ready);
    end
    checks++;
    if (sb.size() < 2) begin
      errors++;
      $display("FAIL bp_rsp got %0d scoreboard entries expected 2", sb.size());
    end else begin
      e = sb.pop_front();
      if (e.owner != 1 || rsp_valid !== 2'b10 || rsp_result !== e.res || rsp_err !== e.err) begin
        errors++;
        $display("FAIL bp_rsp got v=%b res=%h err=%b expected owner %0d res=%h err=%b",
                 rsp_valid, rsp_result, rsp_err, e.owner, e.res, e.err);
      end
    end
    @(negedge clk);
    req_valid = '0;
    settle_and_log();
    @(negedge clk);
    settle_and_log();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL bp_rsp2 got empty scoreboard expected one entry");
    end else begin
      e = sb.pop_front();
      if (e.owner != 0 || rsp_valid !== 2'b01 || rsp_result !== e.res || rsp_err !== e.err) begin
        errors++;
        $display("FAIL bp_rsp2 got v=%b res=%h err=%b expected owner %0d res=%h err=%b",
                 rsp_valid, rsp_result, rsp_err, e.owner, e.res, e.err);
      end
    end
    @(negedge clk);
    settle_and_log();
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    set_req(1, 32'd5, 32'd10, 4'd1);
    req_valid = 2'b10;
    settle_and_log();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL arst_grant got %b expected 10", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    settle_and_log();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_ctl} !== '0) begin
      errors++;
      $display("FAIL arst_outputs got ready=%b v=%b res=%h err=%b a=%h b=%h ctl=%h expected all 0",
               req_ready, rsp_valid, rsp_result, rsp_err, alu_a, alu_b, alu_ctl);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      settle_and_log();
      checks++;
      if (rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL arst_no_rsp cycle %0d got v=%b expected 00", k, rsp_valid);
      end
    end
    @(negedge clk);
    set_req(0, 32'h0000_0100, 32'h0000_0011, 4'd6);
    set_req(1, 32'h0000_0007, 32'h0000_0003, 4'd6);
    req_valid = 2'b11;
    settle_and_log();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL arst_next_grant got %b expected 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    settle_and_log();
    @(negedge clk);
    settle_and_log();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL arst_rsp got empty scoreboard expected one entry");
    end else begin
      e = sb.pop_front();
      if (rsp_valid !== 2'b01 || rsp_result !== e.res || rsp_result !== 32'h0000_0111) begin
        errors++;
        $display("FAIL arst_rsp got v=%b res=%h expected v=01 res=00000111", rsp_valid, rsp_result);
      end
    end
    @(negedge clk);
    settle_and_log();
  endtask

  task automatic test_illegal_op();
    exp_t e;
    @(negedge clk);
    set_req(0, 32'h0000_000F, 32'h0000_0004, 4'hF);
    req_valid = 2'b01;
    settle_and_log();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL illegal_grant got %b expected 01", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    settle_and_log();
    checks++;
    if (alu_ctl !== (CHECK_EN ? 4'h0 : 4'hF)) begin
      errors++;
      $display("FAIL illegal_alu_ctl got %h expected %h", alu_ctl, CHECK_EN ? 4'h0 : 4'hF);
    end
    @(negedge clk);
    settle_and_log();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_result !== (CHECK_EN ? 32'h0 : 32'hB) || rsp_err !== CHECK_EN) begin
      errors++;
      $display("FAIL illegal_rsp got v=%b res=%h err=%b expected v=01 res=%h err=%b",
               rsp_valid, rsp_result, rsp_err, CHECK_EN ? 32'h0 : 32'hB, CHECK_EN);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL illegal_sb got empty scoreboard expected one entry");
    end else begin
      e = sb.pop_front();
      if (rsp_result !== e.res || rsp_err !== e.err) begin
        errors++;
        $display("FAIL illegal_sb got res=%h err=%b expected res=%h err=%b", rsp_result, rsp_err, e.res, e.err);
      end
    end
    @(negedge clk);
    settle_and_log();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctl   = '0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_async_reset();
    test_illegal_op();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d leftover entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got no completion expected finish before 100000");
    $fatal(1);
  end

endmodule
